ups_axi4l_arbiter: RTL

Shares the single ca4l AXI4-Lite master port between NREQ on-chip register-access requesters, such as a control FSM and a telemetry poller. Each requester issues single-beat read or write requests over a req/ack handshake. The block grants requesters round-robin, sequences the AXI4-Lite address, data and response phases, and returns read data and response to the granted requester. A watchdog aborts any transaction stalled by a dead slave.

---
 rtl/ups_axi4l_pkg.sv | 33 +++
 rtl/ups_axi4l_arbiter_rr.sv | 37 +++
 rtl/ups_axi4l_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ups_axi4l_pkg.sv
// Shared types and constants for the AXI4-Lite requester arbiter.
package ups_axi4l_pkg;

  localparam int AXI_AW = 32;
  localparam int AXI_DW = 32;
  localparam int AXI_SW = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  // A watchdog abort reports the same code as a decode error.
  localparam logic [1:0] RESP_ABORT  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_A  = 3'd1,
    ST_RD_D  = 3'd2,
    ST_WR_AW = 3'd3,
    ST_WR_B  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // True in the states where the bus is waiting on a slave handshake.
  function automatic logic is_busy(input state_e s);
    logic b;
    case (s)
      ST_RD_A, ST_RD_D, ST_WR_AW, ST_WR_B: b = 1'b1;
      default:                             b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ups_axi4l_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module ups_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  // Scan requesters starting at ptr and take the first one that is asking.
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) begin
        j = j - NREQ;
      end else begin
        j = j;
      end
      if (!valid && req[j]) begin
        valid    = 1'b1;
        idx      = IW'(j);
        grant[j] = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/ups_axi4l_arbiter.sv
// Shares one AXI4-Lite master port between NREQ single-beat requesters.
// Round-robin grant, full phase sequencing, and a watchdog for dead slaves.
module ups_axi4l_arbiter
  import ups_axi4l_pkg::*;
#(
  parameter int         NREQ    = 2,
  parameter int         TIMEOUT = 256,
  parameter logic [2:0] PROT    = 3'b000
) (
  input  logic               fclk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*32-1:0] req_addr,
  input  logic [NREQ*32-1:0] req_wdata,
  input  logic [NREQ*4-1:0]  req_wstrb,
  output logic [NREQ-1:0]    ack,
  output logic [31:0]        rsp_rdata,
  output logic [1:0]         rsp_resp,
  output logic [31:0]        ca4l_araddr,
  output logic [2:0]         ca4l_arprot,
  output logic               ca4l_arvalid,
  input  logic               ca4l_arready,
  input  logic [31:0]        ca4l_rdata,
  input  logic [1:0]         ca4l_rresp,
  input  logic               ca4l_rvalid,
  output logic               ca4l_rready,
  output logic [31:0]        ca4l_awaddr,
  output logic [2:0]         ca4l_awprot,
  output logic               ca4l_awvalid,
  input  logic               ca4l_awready,
  output logic [31:0]        ca4l_wdata,
  output logic [3:0]         ca4l_wstrb,
  output logic               ca4l_wvalid,
  input  logic               ca4l_wready,
  input  logic [1:0]         ca4l_bresp,
  input  logic               ca4l_bvalid,
  output logic               ca4l_bready
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
  localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT - 1);

  logic [AXI_AW-1:0] addr_a_s  [NREQ];
  logic [AXI_DW-1:0] wdata_a_s [NREQ];
  logic [AXI_SW-1:0] wstrb_a_s [NREQ];

  genvar g;
  for (g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_a_s[g]  = req_addr[32*g +: 32];
    assign wdata_a_s[g] = req_wdata[32*g +: 32];
    assign wstrb_a_s[g] = req_wstrb[4*g +: 4];
  end

  state_e            state_r, state_nx_s;
  logic [IW-1:0]     ptr_r, ptr_nx_s;
  logic [IW-1:0]     gidx_r, gidx_nx_s;
  logic [NREQ-1:0]   goh_r, goh_nx_s;
  logic              aw_done_r, aw_done_nx_s;
  logic              w_done_r, w_done_nx_s;
  logic [CW-1:0]     wd_cnt_r, wd_cnt_nx_s;
  logic [NREQ-1:0]   ack_r, ack_nx_s;
  logic [31:0]       rsp_rdata_r, rsp_rdata_nx_s;
  logic [1:0]        rsp_resp_r, rsp_resp_nx_s;
  logic              arvalid_r, arvalid_nx_s;
  logic [31:0]       araddr_r, araddr_nx_s;
  logic              rready_r, rready_nx_s;
  logic              awvalid_r, awvalid_nx_s;
  logic [31:0]       awaddr_r, awaddr_nx_s;
  logic              wvalid_r, wvalid_nx_s;
  logic [31:0]       wdata_r, wdata_nx_s;
  logic [3:0]        wstrb_r, wstrb_nx_s;
  logic              bready_r, bready_nx_s;

  logic [NREQ-1:0]   gnt_oh_s;
  logic [IW-1:0]     gnt_idx_s;
  logic              gnt_valid_s;
  logic              timeout_s;
  logic              abort_s;
  logic              aw_fin_s;
  logic              w_fin_s;

  ups_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req   (req),
    .ptr   (ptr_r),
    .grant (gnt_oh_s),
    .idx   (gnt_idx_s),
    .valid (gnt_valid_s)
  );

  assign timeout_s = (wd_cnt_r == WD_LIMIT);

  // Next-state and next-output logic; every output is the register of its next value.
  always_comb begin
    state_nx_s     = state_r;
    ptr_nx_s       = ptr_r;
    gidx_nx_s      = gidx_r;
    goh_nx_s       = goh_r;
    aw_done_nx_s   = aw_done_r;
    w_done_nx_s    = w_done_r;
    ack_nx_s       = '0;
    rsp_rdata_nx_s = rsp_rdata_r;
    rsp_resp_nx_s  = rsp_resp_r;
    arvalid_nx_s   = arvalid_r;
    araddr_nx_s    = araddr_r;
    rready_nx_s    = rready_r;
    awvalid_nx_s   = awvalid_r;
    awaddr_nx_s    = awaddr_r;
    wvalid_nx_s    = wvalid_r;
    wdata_nx_s     = wdata_r;
    wstrb_nx_s     = wstrb_r;
    bready_nx_s    = bready_r;
    abort_s        = 1'b0;
    aw_fin_s       = aw_done_r | (awvalid_r & ca4l_awready);
    w_fin_s        = w_done_r | (wvalid_r & ca4l_wready);
    wd_cnt_nx_s    = '0;

    case (state_r)
      ST_IDLE: begin
        if (gnt_valid_s) begin
          gidx_nx_s = gnt_idx_s;
          goh_nx_s  = gnt_oh_s;
          if (req_we[gnt_idx_s]) begin
            state_nx_s   = ST_WR_AW;
            awvalid_nx_s = 1'b1;
            wvalid_nx_s  = 1'b1;
            awaddr_nx_s  = addr_a_s[gnt_idx_s];
            wdata_nx_s   = wdata_a_s[gnt_idx_s];
            wstrb_nx_s   = wstrb_a_s[gnt_idx_s];
            aw_done_nx_s = 1'b0;
            w_done_nx_s  = 1'b0;
          end else begin
            state_nx_s   = ST_RD_A;
            arvalid_nx_s = 1'b1;
            araddr_nx_s  = addr_a_s[gnt_idx_s];
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RD_A: begin
        if (ca4l_arready) begin
          arvalid_nx_s = 1'b0;
          rready_nx_s  = 1'b1;
          state_nx_s   = ST_RD_D;
        end else if (timeout_s) begin
          abort_s = 1'b1;
        end else begin
          state_nx_s = ST_RD_A;
        end
      end
      ST_RD_D: begin
        if (ca4l_rvalid) begin
          rready_nx_s    = 1'b0;
          rsp_rdata_nx_s = ca4l_rdata;
          rsp_resp_nx_s  = ca4l_rresp;
          ack_nx_s       = goh_r;
          state_nx_s     = ST_DONE;
        end else if (timeout_s) begin
          abort_s = 1'b1;
        end else begin
          state_nx_s = ST_RD_D;
        end
      end
      ST_WR_AW: begin
        // Address and data channels complete independently.
        if (awvalid_r && ca4l_awready) begin
          awvalid_nx_s = 1'b0;
          aw_done_nx_s = 1'b1;
        end else begin
          awvalid_nx_s = awvalid_r;
        end
        if (wvalid_r && ca4l_wready) begin
          wvalid_nx_s = 1'b0;
          w_done_nx_s = 1'b1;
        end else begin
          wvalid_nx_s = wvalid_r;
        end
        if (aw_fin_s && w_fin_s) begin
          bready_nx_s = 1'b1;
          state_nx_s  = ST_WR_B;
        end else if (timeout_s) begin
          abort_s = 1'b1;
        end else begin
          state_nx_s = ST_WR_AW;
        end
      end
      ST_WR_B: begin
        if (ca4l_bvalid) begin
          bready_nx_s    = 1'b0;
          rsp_rdata_nx_s = '0;
          rsp_resp_nx_s  = ca4l_bresp;
          ack_nx_s       = goh_r;
          state_nx_s     = ST_DONE;
        end else if (timeout_s) begin
          abort_s = 1'b1;
        end else begin
          state_nx_s = ST_WR_B;
        end
      end
      ST_DONE: begin
        // Response is only meaningful alongside ack; clear it afterwards.
        rsp_rdata_nx_s = '0;
        rsp_resp_nx_s  = RESP_OKAY;
        if (gidx_r == LAST_IDX) begin
          ptr_nx_s = '0;
        end else begin
          ptr_nx_s = gidx_r + IW'(1);
        end
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase

    // Dead-slave abort: drop every handshake signal and complete with an error.
    if (abort_s) begin
      arvalid_nx_s   = 1'b0;
      rready_nx_s    = 1'b0;
      awvalid_nx_s   = 1'b0;
      wvalid_nx_s    = 1'b0;
      bready_nx_s    = 1'b0;
      rsp_rdata_nx_s = '0;
      rsp_resp_nx_s  = RESP_ABORT;
      ack_nx_s       = goh_r;
      state_nx_s     = ST_DONE;
    end else begin
      abort_s = 1'b0;
    end

    // Watchdog restarts on every state change and only runs while waiting on the slave.
    if (state_nx_s != state_r) begin
      wd_cnt_nx_s = '0;
    end else if (is_busy(state_r)) begin
      wd_cnt_nx_s = wd_cnt_r + CW'(1);
    end else begin
      wd_cnt_nx_s = '0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      ptr_r       <= '0;
      gidx_r      <= '0;
      goh_r       <= '0;
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
      wd_cnt_r    <= '0;
      ack_r       <= '0;
      rsp_rdata_r <= '0;
      rsp_resp_r  <= 2'b00;
      arvalid_r   <= 1'b0;
      araddr_r    <= '0;
      rready_r    <= 1'b0;
      awvalid_r   <= 1'b0;
      awaddr_r    <= '0;
      wvalid_r    <= 1'b0;
      wdata_r     <= '0;
      wstrb_r     <= '0;
      bready_r    <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      ptr_r       <= ptr_nx_s;
      gidx_r      <= gidx_nx_s;
      goh_r       <= goh_nx_s;
      aw_done_r   <= aw_done_nx_s;
      w_done_r    <= w_done_nx_s;
      wd_cnt_r    <= wd_cnt_nx_s;
      ack_r       <= ack_nx_s;
      rsp_rdata_r <= rsp_rdata_nx_s;
      rsp_resp_r  <= rsp_resp_nx_s;
      arvalid_r   <= arvalid_nx_s;
      araddr_r    <= araddr_nx_s;
      rready_r    <= rready_nx_s;
      awvalid_r   <= awvalid_nx_s;
      awaddr_r    <= awaddr_nx_s;
      wvalid_r    <= wvalid_nx_s;
      wdata_r     <= wdata_nx_s;
      wstrb_r     <= wstrb_nx_s;
      bready_r    <= bready_nx_s;
    end
  end

  assign ack          = ack_r;
  assign rsp_rdata    = rsp_rdata_r;
  assign rsp_resp     = rsp_resp_r;
  assign ca4l_araddr  = araddr_r;
  assign ca4l_arprot  = PROT;
  assign ca4l_arvalid = arvalid_r;
  assign ca4l_rready  = rready_r;
  assign ca4l_awaddr  = awaddr_r;
  assign ca4l_awprot  = PROT;
  assign ca4l_awvalid = awvalid_r;
  assign ca4l_wdata   = wdata_r;
  assign ca4l_wstrb   = wstrb_r;
  assign ca4l_wvalid  = wvalid_r;
  assign ca4l_bready  = bready_r;

endmodule
